// File: rtl/mux_rx.sv
// mux_rx: receive-side word steering behind CorePCS.
// Tracks comma-based link status, forwards words to the fiber packet path,
// or checks them against a self-synchronising PRBS-7 sequence for link
// qualification (lock flag, error pulse, saturating errored-word count).
module mux_rx #(
    parameter int COMMA_LOCK  = 8,
    parameter int PRBS_LOCK_N = 8,
    parameter int PRBS_LOSS_N = 8,
    parameter int CNT_W       = 32
) (
    input  logic             RX_CLK,
    input  logic             RESET,
    input  logic [15:0]      RX_DATA,
    input  logic [1:0]       RX_KCHAR,
    input  logic             RX_VALID,
    input  logic             PRBS_EN,
    input  logic             PRBS_CLR,
    output logic [15:0]      FIBER_DATA,
    output logic [1:0]       FIBER_KCHAR,
    output logic             FIBER_VALID,
    output logic             LINK_UP,
    output logic             PRBS_LOCKED,
    output logic             PRBS_ERR,
    output logic [CNT_W-1:0] PRBS_ERR_CNT
);

    localparam int COMMA_W = $clog2(COMMA_LOCK + 1);
    localparam int RUN_W   = $clog2(PRBS_LOCK_N + 1);
    localparam int LOSS_W  = $clog2(PRBS_LOSS_N + 1);

    typedef enum logic {
        L_DOWN,
        L_UP
    } link_state_t;

    typedef enum logic [1:0] {
        P_IDLE,
        P_SYNC,
        P_LOCKED
    } prbs_state_t;

    // ------------------------------------------------------------------
    // Link (comma lock) state
    // ------------------------------------------------------------------
    link_state_t        link_state_q, link_state_d;
    logic [COMMA_W-1:0] comma_run_q, comma_run_d;
    logic               is_comma;

    assign is_comma = (RX_DATA[7:0] == 8'hBC) && (RX_KCHAR == 2'b01);

    // Link FSM next state: count consecutive valid commas while down, drop on any invalid cycle while up.
    always_comb begin
        link_state_d = link_state_q;
        comma_run_d  = comma_run_q;
        unique case (link_state_q)
            L_DOWN: begin
                if (RX_VALID && is_comma) begin
                    if (comma_run_q == COMMA_W'(COMMA_LOCK - 1)) begin
                        link_state_d = L_UP;
                        comma_run_d  = '0;
                    end else begin
                        comma_run_d = comma_run_q + COMMA_W'(1);
                    end
                end else begin
                    comma_run_d = '0;
                end
            end
            L_UP: begin
                comma_run_d = '0;
                if (!RX_VALID) begin
                    link_state_d = L_DOWN;
                end
            end
            default: begin
                link_state_d = L_DOWN;
                comma_run_d  = '0;
            end
        endcase
    end

    // Link FSM state register.
    always_ff @(posedge RX_CLK) begin
        if (RESET) begin
            link_state_q <= L_DOWN;
            comma_run_q  <= '0;
        end else begin
            link_state_q <= link_state_d;
            comma_run_q  <= comma_run_d;
        end
    end

    assign LINK_UP = (link_state_q == L_UP);

    // ------------------------------------------------------------------
    // Fiber path: one register stage, zeroed while the PRBS checker owns the stream
    // ------------------------------------------------------------------
    logic [15:0] fiber_data_q, fiber_data_d;
    logic [1:0]  fiber_kchar_q, fiber_kchar_d;
    logic        fiber_valid_q, fiber_valid_d;

    // Fiber next values: pass the word through unless PRBS mode is selected.
    always_comb begin
        fiber_data_d  = RX_DATA;
        fiber_kchar_d = RX_KCHAR;
        fiber_valid_d = RX_VALID & LINK_UP & ~PRBS_EN;
        if (PRBS_EN) begin
            fiber_data_d  = '0;
            fiber_kchar_d = '0;
        end
    end

    // Fiber output registers.
    always_ff @(posedge RX_CLK) begin
        if (RESET) begin
            fiber_data_q  <= '0;
            fiber_kchar_q <= '0;
            fiber_valid_q <= 1'b0;
        end else begin
            fiber_data_q  <= fiber_data_d;
            fiber_kchar_q <= fiber_kchar_d;
            fiber_valid_q <= fiber_valid_d;
        end
    end

    assign FIBER_DATA  = fiber_data_q;
    assign FIBER_KCHAR = fiber_kchar_q;
    assign FIBER_VALID = fiber_valid_q;

    // ------------------------------------------------------------------
    // PRBS-7 checker (x^7 + x^6 + 1, self-synchronising)
    // ------------------------------------------------------------------
    // Only the last 7 bits (in time) of the previous word reach the taps of
    // the current word, so that is all of "prev" that needs storing.
    prbs_state_t       prbs_state_q, prbs_state_d;
    logic [6:0]        prev_q, prev_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [LOSS_W-1:0] loss_q, loss_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    // Stream in time order MSB first: {prev[6:0], cur[15:0]}.
    logic [22:0] stream;
    logic [15:0] exp_bits;
    logic        word_bad;

    assign stream = {prev_q, RX_DATA};

    // Each current bit must equal the XOR of the bits 7 and 6 positions earlier in time.
    for (genvar gi = 0; gi < 16; gi++) begin : g_prbs_exp
        assign exp_bits[gi] = stream[gi + 7] ^ stream[gi + 6];
    end

    assign word_bad = (exp_bits != RX_DATA) || (RX_KCHAR != 2'b00);

    // PRBS FSM next state, error pulse and saturating error count.
    always_comb begin
        prbs_state_d = prbs_state_q;
        prev_d       = prev_q;
        run_d        = run_q;
        loss_d       = loss_q;
        err_d        = 1'b0;
        err_cnt_d    = err_cnt_q;
        if (!PRBS_EN) begin
            prbs_state_d = P_IDLE;
            run_d        = '0;
            loss_d       = '0;
        end else if (RX_VALID) begin
            // Every checked word becomes the reference, errored or not.
            prev_d = RX_DATA[6:0];
            unique case (prbs_state_q)
                P_IDLE: begin
                    prbs_state_d = P_SYNC;
                    run_d        = '0;
                    loss_d       = '0;
                end
                P_SYNC: begin
                    if (word_bad) begin
                        run_d = '0;
                    end else if (run_q == RUN_W'(PRBS_LOCK_N - 1)) begin
                        prbs_state_d = P_LOCKED;
                        run_d        = '0;
                        loss_d       = '0;
                    end else begin
                        run_d = run_q + RUN_W'(1);
                    end
                end
                P_LOCKED: begin
                    if (word_bad) begin
                        err_d = 1'b1;
                        if (err_cnt_q != {CNT_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end
                        if (loss_q == LOSS_W'(PRBS_LOSS_N - 1)) begin
                            prbs_state_d = P_SYNC;
                            run_d        = '0;
                            loss_d       = '0;
                        end else begin
                            loss_d = loss_q + LOSS_W'(1);
                        end
                    end else begin
                        loss_d = '0;
                    end
                end
                default: begin
                    prbs_state_d = P_IDLE;
                    run_d        = '0;
                    loss_d       = '0;
                end
            endcase
        end
        // Clear takes priority over a coincident increment.
        if (PRBS_CLR) begin
            err_cnt_d = '0;
        end
    end

    // PRBS checker state registers.
    always_ff @(posedge RX_CLK) begin
        if (RESET) begin
            prbs_state_q <= P_IDLE;
            prev_q       <= '0;
            run_q        <= '0;
            loss_q       <= '0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            prbs_state_q <= prbs_state_d;
            prev_q       <= prev_d;
            run_q        <= run_d;
            loss_q       <= loss_d;
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign PRBS_LOCKED  = (prbs_state_q == P_LOCKED);
    assign PRBS_ERR     = err_q;
    assign PRBS_ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_mux_rx.sv
// tb_mux_rx: directed bench for mux_rx. Fiber words and PRBS error pulses are
// pushed into expectation queues as stimulus is issued; a negedge monitor pops
// and compares whenever the DUT presents FIBER_VALID or PRBS_ERR.
module tb_mux_rx;

    localparam int CW = 4;

    logic          clk;
    logic          RESET;
    logic [15:0]   RX_DATA;
    logic [1:0]    RX_KCHAR;
    logic          RX_VALID;
    logic          PRBS_EN;
    logic          PRBS_CLR;
    logic [15:0]   FIBER_DATA;
    logic [1:0]    FIBER_KCHAR;
    logic          FIBER_VALID;
    logic          LINK_UP;
    logic          PRBS_LOCKED;
    logic          PRBS_ERR;
    logic [CW-1:0] PRBS_ERR_CNT;

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0]   fiber_q[$];
    logic [CW-1:0] err_q[$];

    // PRBS-7 generator history: h[0] is the newest bit, h[6] is 7 bits back.
    logic [6:0] h;

    mux_rx #(
        .COMMA_LOCK (8),
        .PRBS_LOCK_N(8),
        .PRBS_LOSS_N(8),
        .CNT_W      (CW)
    ) dut (
        .RX_CLK      (clk),
        .RESET       (RESET),
        .RX_DATA     (RX_DATA),
        .RX_KCHAR    (RX_KCHAR),
        .RX_VALID    (RX_VALID),
        .PRBS_EN     (PRBS_EN),
        .PRBS_CLR    (PRBS_CLR),
        .FIBER_DATA  (FIBER_DATA),
        .FIBER_KCHAR (FIBER_KCHAR),
        .FIBER_VALID (FIBER_VALID),
        .LINK_UP     (LINK_UP),
        .PRBS_LOCKED (PRBS_LOCKED),
        .PRBS_ERR    (PRBS_ERR),
        .PRBS_ERR_CNT(PRBS_ERR_CNT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Apply one word for one clock; outputs for it are valid on return.
    task automatic drive(input logic [15:0] d, input logic [1:0] k, input logic v,
                         input logic en, input logic clr, input logic fexp,
                         input logic eexp, input logic [CW-1:0] ecnt);
        RX_DATA  = d;
        RX_KCHAR = k;
        RX_VALID = v;
        PRBS_EN  = en;
        PRBS_CLR = clr;
        if (fexp) fiber_q.push_back({k, d});
        if (eexp) err_q.push_back(ecnt);
        @(posedge clk);
        #1;
    endtask

    task automatic comma();
        drive(16'h00BC, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic gen_word(output logic [15:0] w);
        logic nb;
        for (int b = 15; b >= 0; b--) begin
            nb   = h[6] ^ h[5];
            w[b] = nb;
            h    = {h[5:0], nb};
        end
    endtask

    // Flipping bit 15 (earliest in time) corrupts only this word's check.
    task automatic prbs_word(input logic flip, input logic [1:0] k, input logic clr,
                             input logic eexp, input logic [CW-1:0] ecnt);
        logic [15:0] w;
        gen_word(w);
        if (flip) w[15] = ~w[15];
        drive(w, k, 1'b1, 1'b1, clr, 1'b0, eexp, ecnt);
    endtask

    // Monitor: compare every presented fiber word and error pulse against the queues.
    always @(negedge clk) begin
        if (FIBER_VALID === 1'b1) begin
            n_checks++;
            if (fiber_q.size() == 0) begin
                n_fail++;
                $display("FAIL fiber_word: got %h/%h, required no word", FIBER_KCHAR, FIBER_DATA);
            end else begin
                logic [17:0] e;
                e = fiber_q.pop_front();
                if ({FIBER_KCHAR, FIBER_DATA} !== e) begin
                    n_fail++;
                    $display("FAIL fiber_word: got %h/%h, required %h/%h",
                             FIBER_KCHAR, FIBER_DATA, e[17:16], e[15:0]);
                end else begin
                    $display("ok   fiber_word: %h/%h", FIBER_KCHAR, FIBER_DATA);
                end
            end
        end
        if (PRBS_ERR === 1'b1) begin
            n_checks++;
            if (err_q.size() == 0) begin
                n_fail++;
                $display("FAIL prbs_err_pulse: got pulse cnt=%0d, required no pulse", PRBS_ERR_CNT);
            end else begin
                logic [CW-1:0] e;
                e = err_q.pop_front();
                if (PRBS_ERR_CNT !== e) begin
                    n_fail++;
                    $display("FAIL prbs_err_pulse: got cnt=%0d, required cnt=%0d", PRBS_ERR_CNT, e);
                end else begin
                    $display("ok   prbs_err_pulse: cnt=%0d", PRBS_ERR_CNT);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_link_up"},     32'(LINK_UP),      32'd0);
        check({tag, "_prbs_locked"}, 32'(PRBS_LOCKED),  32'd0);
        check({tag, "_prbs_err"},    32'(PRBS_ERR),     32'd0);
        check({tag, "_err_cnt"},     32'(PRBS_ERR_CNT), 32'd0);
        check({tag, "_fiber_valid"}, 32'(FIBER_VALID),  32'd0);
        check({tag, "_fiber_data"},  32'({FIBER_KCHAR, FIBER_DATA}), 32'd0);
    endtask

    initial begin
        RESET    = 1'b1;
        RX_DATA  = '0;
        RX_KCHAR = '0;
        RX_VALID = 1'b0;
        PRBS_EN  = 1'b0;
        PRBS_CLR = 1'b0;
        h        = 7'h7F;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        RESET = 1'b0;

        // Link: 7 commas then a data word must not bring the link up.
        for (int i = 0; i < 7; i++) comma();
        drive(16'h1234, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("link_7_commas_then_data", 32'(LINK_UP), 32'd0);
        for (int i = 0; i < 8; i++) begin
            comma();
            if (i == 6) check("link_after_7th_comma", 32'(LINK_UP), 32'd0);
        end
        check("link_after_8th_comma", 32'(LINK_UP), 32'd1);
        drive(16'h00BC, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("link_drop_on_invalid", 32'(LINK_UP), 32'd0);
        for (int i = 0; i < 8; i++) comma();
        check("link_relock", 32'(LINK_UP), 32'd1);

        // Fiber path.
        drive(16'h1234, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check("fiber_data_1234", 32'(FIBER_DATA), 32'h1234);
        check("fiber_valid_1234", 32'(FIBER_VALID), 32'd1);
        drive(16'hBEEF, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);

        // PRBS acquisition: first word seeds, 8 more good words lock.
        prbs_word(1'b0, 2'b00, 1'b0, 1'b0, '0);
        check("fiber_valid_prbs_mode", 32'(FIBER_VALID), 32'd0);
        check("fiber_data_prbs_mode", 32'({FIBER_KCHAR, FIBER_DATA}), 32'd0);
        for (int i = 2; i <= 9; i++) begin
            prbs_word(1'b0, 2'b00, 1'b0, 1'b0, '0);
            if (i == 8) check("prbs_not_locked_word8", 32'(PRBS_LOCKED), 32'd0);
        end
        check("prbs_locked_word9", 32'(PRBS_LOCKED), 32'd1);
        for (int i = 0; i < 1000; i++) prbs_word(1'b0, 2'b00, 1'b0, 1'b0, '0);
        check("prbs_clean_1000_cnt", 32'(PRBS_ERR_CNT), 32'd0);
        check("prbs_clean_1000_locked", 32'(PRBS_LOCKED), 32'd1);

        // Isolated single-bit errors.
        for (int e = 1; e <= 3; e++) begin
            prbs_word(1'b1, 2'b00, 1'b0, 1'b1, CW'(e));
            repeat (3) prbs_word(1'b0, 2'b00, 1'b0, 1'b0, '0);
        end
        check("prbs_three_errors_cnt", 32'(PRBS_ERR_CNT), 32'd3);
        prbs_word(1'b0, 2'b00, 1'b1, 1'b0, '0);
        check("prbs_clr", 32'(PRBS_ERR_CNT), 32'd0);
        prbs_word(1'b1, 2'b00, 1'b1, 1'b1, CW'(0));
        check("prbs_clr_wins_over_err", 32'(PRBS_ERR_CNT), 32'd0);
        prbs_word(1'b0, 2'b01, 1'b0, 1'b1, CW'(1));
        check("prbs_kchar_is_error", 32'(PRBS_ERR_CNT), 32'd1);
        prbs_word(1'b0, 2'b00, 1'b1, 1'b0, '0);
        check("prbs_clr_again", 32'(PRBS_ERR_CNT), 32'd0);

        // Loss of lock after 8 consecutive errored words.
        for (int e = 1; e <= 8; e++) begin
            prbs_word(1'b1, 2'b00, 1'b0, 1'b1, CW'(e));
            if (e == 7) check("prbs_still_locked_7_errs", 32'(PRBS_LOCKED), 32'd1);
        end
        check("prbs_unlocked_8_errs", 32'(PRBS_LOCKED), 32'd0);
        check("prbs_cnt_8_errs", 32'(PRBS_ERR_CNT), 32'd8);
        for (int i = 1; i <= 8; i++) begin
            prbs_word(1'b0, 2'b00, 1'b0, 1'b0, '0);
            if (i == 7) check("prbs_resync_7_good", 32'(PRBS_LOCKED), 32'd0);
        end
        check("prbs_relocked", 32'(PRBS_LOCKED), 32'd1);

        // Saturation of the 4-bit count.
        for (int e = 9; e <= 16; e++) begin
            prbs_word(1'b1, 2'b00, 1'b0, 1'b1, (e > 15) ? CW'(15) : CW'(e));
        end
        check("prbs_cnt_saturated", 32'(PRBS_ERR_CNT), 32'd15);
        for (int i = 0; i < 8; i++) prbs_word(1'b0, 2'b00, 1'b0, 1'b0, '0);
        check("prbs_relocked_2", 32'(PRBS_LOCKED), 32'd1);

        // Leaving PRBS mode drops lock but keeps the count.
        drive(16'hA5A5, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check("prbs_en_off_unlocked", 32'(PRBS_LOCKED), 32'd0);
        check("prbs_en_off_cnt_kept", 32'(PRBS_ERR_CNT), 32'd15);

        // Mid-stream reset.
        RESET = 1'b1;
        comma();
        check_all_zero("midreset");
        comma();
        RESET = 1'b0;
        for (int i = 0; i < 7; i++) comma();
        check("post_reset_7_commas", 32'(LINK_UP), 32'd0);
        comma();
        check("post_reset_8_commas", 32'(LINK_UP), 32'd1);

        drive(16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        #1;
        check("fiber_queue_drained", 32'(fiber_q.size()), 32'd0);
        check("err_queue_drained", 32'(err_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
